riscv_trap_redirect: RTL and testbench

Parametrised, registered trap-redirect controller for the writeback stage. It arbitrates among NUM_SRC prioritised trap sources and an mret return. It holds requests while the pipeline is stalled, then issues a one-cycle PC-select redirect and a flush pulse of configurable length. It sits between the CSR/trap detection logic and the fetch-stage PC mux and the pipeline flush network.

---
 rtl/riscv_trap_pkg.sv | 9 +
 rtl/riscv_trap_prio_enc.sv | 16 +
 rtl/riscv_trap_redirect.sv | 102 ++++++++++
 tb/tb_riscv_trap_redirect.sv | 139 +++++++++++++
 4 files changed

// File: rtl/riscv_trap_pkg.sv
// riscv_trap_pkg: shared state/kind enums and PC-select encodings for the trap redirect block
package riscv_trap_pkg;
  typedef enum logic [1:0] {IDLE, PEND, REDIRECT, FLUSH} state_e;
  typedef enum logic {TRAP, MRET} kind_e;
  localparam logic [1:0] PCSEL_SEQ  = 2'b00;
  localparam logic [1:0] PCSEL_TRAP = 2'b01;
  localparam logic [1:0] PCSEL_MRET = 2'b10;
  localparam int CNT_W = 3;
endpackage

// File: rtl/riscv_trap_prio_enc.sv
// riscv_trap_prio_enc: lowest-index-first priority encoder with valid flag
module riscv_trap_prio_enc #(
  parameter int NUM_SRC = 4,
  localparam int CAUSE_W = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] i_req,
  output logic               o_valid,
  output logic [CAUSE_W-1:0] o_idx
);
  always_comb begin
    o_valid = |i_req;
    o_idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--)
      if (i_req[i]) o_idx = CAUSE_W'(i);
  end
endmodule

// File: rtl/riscv_trap_redirect.sv
// riscv_trap_redirect: registered trap/mret redirect controller with sticky pending and flush sequencing
// Define RISCV_TRAP_MRET_FLUSH_EN to make mret flush the pipeline like a trap.
module riscv_trap_redirect
  import riscv_trap_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int FLUSH_CYCLES = 2,
  localparam int CAUSE_W = $clog2(NUM_SRC)
) (
  input  logic               i_riscv_clk,
  input  logic               i_riscv_rst,
  input  logic [NUM_SRC-1:0] i_riscv_trap_req,
  input  logic               i_riscv_trap_mret,
  input  logic               i_riscv_trap_stall,
  output logic [1:0]         o_riscv_trap_pcsel,
  output logic               o_riscv_trap_flush,
  output logic               o_riscv_trap_taken,
  output logic [CAUSE_W-1:0] o_riscv_trap_cause_id,
  output logic               o_riscv_trap_busy
);
`ifdef RISCV_TRAP_MRET_FLUSH_EN
  localparam bit MRET_FLUSH = 1'b1;
`else
  localparam bit MRET_FLUSH = 1'b0;
`endif
  localparam int FL_INIT = (FLUSH_CYCLES > 1) ? FLUSH_CYCLES - 2 : 0;

  state_e               r_state, w_state_nx;
  kind_e                r_kind, w_kind_nx;
  logic [NUM_SRC-1:0]   r_pend, w_pend_nx, w_cand, w_clr;
  logic [CNT_W-1:0]     r_cnt, w_cnt_nx;
  logic [1:0]           r_pcsel, w_pcsel_nx;
  logic                 r_flush, w_flush_nx, r_taken, w_taken_nx, w_redir, w_valid;
  logic [CAUSE_W-1:0]   r_cause, w_cause_nx, w_win;

  assign w_cand = r_pend | i_riscv_trap_req;

  riscv_trap_prio_enc #(.NUM_SRC(NUM_SRC)) u_enc (
    .i_req   (w_cand),
    .o_valid (w_valid),
    .o_idx   (w_win)
  );

  always_ff @(posedge i_riscv_clk) begin
    if (!i_riscv_rst) begin
      r_state <= IDLE;
      r_kind  <= TRAP;
      r_pend  <= '0;
      r_cnt   <= '0;
      r_pcsel <= PCSEL_SEQ;
      r_flush <= 1'b0;
      r_taken <= 1'b0;
      r_cause <= '0;
    end else begin
      r_state <= w_state_nx;
      r_kind  <= w_kind_nx;
      r_pend  <= w_pend_nx;
      r_cnt   <= w_cnt_nx;
      r_pcsel <= w_pcsel_nx;
      r_flush <= w_flush_nx;
      r_taken <= w_taken_nx;
      r_cause <= w_cause_nx;
    end
  end

  // mret only counts on entry from IDLE; a latched mret yields to any trap while pending
  always_comb begin
    w_state_nx = r_state;
    w_kind_nx = r_kind;
    case (r_state)
      IDLE: if (w_valid || i_riscv_trap_mret) begin
        w_state_nx = i_riscv_trap_stall ? PEND : REDIRECT;
        w_kind_nx = w_valid ? TRAP : MRET;
      end
      PEND: begin
        w_kind_nx = w_valid ? TRAP : r_kind;
        w_state_nx = i_riscv_trap_stall ? PEND : REDIRECT;
      end
      REDIRECT: w_state_nx = (FLUSH_CYCLES > 1 && (r_kind == TRAP || MRET_FLUSH)) ? FLUSH : IDLE;
      FLUSH: w_state_nx = (r_cnt == '0) ? IDLE : FLUSH;
      default: w_state_nx = IDLE;
    endcase
  end

  // outputs are computed from the next state so they register in step with it
  always_comb begin
    w_redir = w_state_nx == REDIRECT;
    w_pcsel_nx = w_redir ? ((w_kind_nx == TRAP) ? PCSEL_TRAP : PCSEL_MRET) : PCSEL_SEQ;
    w_flush_nx = (w_state_nx == FLUSH) || (w_redir && (w_kind_nx == TRAP || MRET_FLUSH));
    w_taken_nx = w_redir && (w_kind_nx == TRAP);
    w_cause_nx = w_taken_nx ? w_win : '0;
    w_clr = (r_state == REDIRECT && r_kind == TRAP) ? (NUM_SRC'(1) << r_cause) : '0;
    w_pend_nx = w_cand & ~w_clr;
    w_cnt_nx = (w_state_nx != FLUSH) ? '0 : (r_state == FLUSH) ? r_cnt - CNT_W'(1) : CNT_W'(FL_INIT);
  end

  assign o_riscv_trap_pcsel = r_pcsel;
  assign o_riscv_trap_flush = r_flush;
  assign o_riscv_trap_taken = r_taken;
  assign o_riscv_trap_cause_id = r_cause;
  assign o_riscv_trap_busy = (r_state != IDLE) || (|r_pend);
endmodule

// File: tb/tb_riscv_trap_redirect.sv
// tb_riscv_trap_redirect: directed and random checks of the trap redirect block against a sequence-position model
module tb_riscv_trap_redirect;
  localparam int NS = 4;
  localparam int FC = 2;
`ifdef RISCV_TRAP_MRET_FLUSH_EN
  localparam bit MF = 1'b1;
`else
  localparam bit MF = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, mret = 1'b0, stall = 1'b0;
  logic [NS-1:0] req = '0;
  logic [1:0] pcsel, cause;
  logic flush, taken, busy;
  int checks = 0, errors = 0;
  bit [NS-1:0] m_pend;
  int m_pos, m_len, m_cause;
  bit m_trap, m_wait, m_wmret;
  logic [1:0] e_pcsel, e_cause;
  logic e_flush, e_taken, e_busy;

  always #5 clk = ~clk;

  riscv_trap_redirect #(.NUM_SRC(NS), .FLUSH_CYCLES(FC)) dut (
    .i_riscv_clk          (clk),
    .i_riscv_rst          (rst_n),
    .i_riscv_trap_req     (req),
    .i_riscv_trap_mret    (mret),
    .i_riscv_trap_stall   (stall),
    .o_riscv_trap_pcsel   (pcsel),
    .o_riscv_trap_flush   (flush),
    .o_riscv_trap_taken   (taken),
    .o_riscv_trap_cause_id(cause),
    .o_riscv_trap_busy    (busy)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // model: a redirect is a sequence of m_len cycles; m_pos is the position within it (0 = none)
  task automatic model(input bit rn, input bit [NS-1:0] rq, input bit mr, input bit st);
    bit [NS-1:0] cand;
    bit want_mret;
    cand = m_pend | rq;
    e_pcsel = 0; e_flush = 0; e_taken = 0; e_cause = 0;
    if (!rn) begin
      m_pend = 0; m_pos = 0; m_wait = 0; m_wmret = 0;
    end else if (m_pos > 0) begin
      if (m_pos == 1 && m_trap) cand[m_cause] = 1'b0;
      m_pend = cand;
      m_pos = (m_pos < m_len) ? m_pos + 1 : 0;
      e_flush = m_pos > 0;
    end else begin
      want_mret = m_wait ? m_wmret : mr;
      m_pend = cand;
      if (cand != 0 || want_mret) begin
        if (st) begin
          m_wait = 1; m_wmret = want_mret;
        end else begin
          m_wait = 0; m_wmret = 0;
          m_trap = cand != 0;
          for (int i = NS - 1; i >= 0; i--) if (cand[i]) m_cause = i;
          m_pos = 1;
          m_len = (m_trap || MF) ? FC : 1;
          e_pcsel = m_trap ? 2'b01 : 2'b10;
          e_taken = m_trap;
          e_cause = m_trap ? 2'(m_cause) : 2'd0;
          e_flush = m_trap || MF;
        end
      end
    end
    e_busy = m_pos > 0 || m_wait || m_pend != 0;
  endtask

  task automatic step(input bit rn, input bit [NS-1:0] rq, input bit mr, input bit st);
    rst_n = rn; req = rq; mret = mr; stall = st;
    @(posedge clk);
    model(rn, rq, mr, st);
    #1;
    chk("pcsel", 8'(pcsel), 8'(e_pcsel));
    chk("flush", 8'(flush), 8'(e_flush));
    chk("taken", 8'(taken), 8'(e_taken));
    if (e_taken || !rn) chk("cause", 8'(cause), 8'(e_cause));
    chk("busy", 8'(busy), 8'(e_busy));
  endtask

  initial begin
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("rst_pcsel", 8'(pcsel), 8'd0);
    chk("rst_busy", 8'(busy), 8'd0);
    step(1, 4'b0100, 0, 0);
    chk("t1_redir", {pcsel, flush, taken, 2'b00, cause}, 8'b01110010);
    step(1, 0, 0, 0);
    chk("t1_flush", {pcsel, flush, taken}, 4'b0010);
    step(1, 0, 0, 0);
    chk("t1_done", {flush, busy}, 2'b00);
    step(1, 4'b1010, 0, 0);
    chk("t2_first", 8'(cause), 8'd1);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("t2_gap_busy", 8'(busy), 8'd1);
    step(1, 0, 0, 0);
    chk("t2_second", {taken, cause}, 3'b111);
    repeat (3) step(1, 0, 0, 0);
    step(1, 0, 1, 1);
    step(1, 0, 0, 1);
    step(1, 4'b0001, 0, 1);
    step(1, 0, 0, 1);
    step(1, 0, 0, 1);
    chk("t3_held", 8'(pcsel), 8'd0);
    step(1, 0, 0, 0);
    chk("t3_trap", {pcsel, cause}, 4'b0100);
    repeat (4) step(1, 0, 0, 0);
    step(1, 0, 1, 0);
    chk("t4_mret", {pcsel, taken, flush}, {2'b10, 1'b0, MF});
    step(1, 0, 0, 0);
    chk("t4_tail", {pcsel, flush}, {2'b00, MF});
    repeat (2) step(1, 0, 0, 0);
    step(1, 4'b0010, 1, 0);
    chk("t5_trap_wins", 8'(pcsel), 8'd1);
    repeat (4) step(1, 0, 0, 0);
    step(1, 4'b0001, 0, 0);
    step(1, 4'b1000, 0, 0);
    chk("t6_in_flush", {pcsel, flush}, 3'b001);
    step(0, 0, 0, 0);
    chk("t6_rst", {pcsel, flush, taken, cause, busy}, 7'd0);
    repeat (5) step(1, 0, 0, 0);
    for (int n = 0; n < 3000; n++)
      step(($urandom % 250) != 0, ($urandom % 5 == 0) ? 4'($urandom) : 4'd0,
           ($urandom % 7) == 0, ($urandom % 3) == 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
